// File: rtl/regfile_port_ctrl.sv
// Write-port arbiter, SR2 read-port sharer and clear-all sequencer for the 8x16 register file.
// Core normally wins writes; a starved host write is forced through after STARVE_MAX losses.
module regfile_port_ctrl #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        core_wr_valid,
  input  logic [2:0]  core_wr_idx,
  input  logic [15:0] core_wr_data,
  output logic        core_wr_ready,
  input  logic        host_wr_valid,
  input  logic [2:0]  host_wr_idx,
  input  logic [15:0] host_wr_data,
  output logic        host_wr_ready,
  input  logic        core_sr2_use,
  input  logic [2:0]  core_sr2_idx,
  input  logic        host_rd_valid,
  input  logic [2:0]  host_rd_idx,
  output logic        host_rd_ready,
  output logic [15:0] host_rd_data,
  output logic        host_rd_data_valid,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [2:0]  rf_DR,
  output logic [15:0] rf_Q,
  output logic        rf_load,
  output logic [2:0]  rf_SR2,
  input  logic [15:0] rf_SR2_OUT
);

  // state | meaning
  // IDLE  | normal write arbitration and host reads
  // CLEAR | writing zero to R0..R7, one register per cycle
  // DONE  | single cycle after the last clear write, clr_done high
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  localparam logic [3:0] WAIT_MAX = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  logic [3:0]  host_wait_q, host_wait_d;
  logic [2:0]  clr_cnt_q, clr_cnt_d;
  logic        rf_load_q, rf_load_d;
  logic [2:0]  rf_dr_q, rf_dr_d;
  logic [15:0] rf_wdata_q, rf_wdata_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic        rd_valid_q, rd_valid_d;
  logic        host_win, core_win;

  always_comb begin
    state_d       = state_q;
    host_wait_d   = host_wait_q;
    clr_cnt_d     = clr_cnt_q;
    rf_load_d     = 1'b0;
    rf_dr_d       = rf_dr_q;
    rf_wdata_d    = rf_wdata_q;
    host_win      = 1'b0;
    core_win      = 1'b0;
    host_rd_ready = 1'b0;

    case (state_q)
      IDLE: begin
        if (!clr_start) begin
          host_win      = host_wr_valid && (!core_wr_valid || host_wait_q == WAIT_MAX);
          core_win      = core_wr_valid && !host_win;
          host_rd_ready = host_rd_valid && !core_sr2_use;
        end
        if (!host_wr_valid || host_win) begin
          host_wait_d = 4'd0;
        end else if (host_wait_q != WAIT_MAX) begin
          host_wait_d = host_wait_q + 4'd1;
        end
        // The first clear write is launched here so it lands in the first CLEAR cycle.
        if (clr_start) begin
          state_d    = CLEAR;
          clr_cnt_d  = 3'd0;
          rf_load_d  = 1'b1;
          rf_dr_d    = 3'd0;
          rf_wdata_d = 16'd0;
        end else if (host_win) begin
          rf_load_d  = 1'b1;
          rf_dr_d    = host_wr_idx;
          rf_wdata_d = host_wr_data;
        end else if (core_win) begin
          rf_load_d  = 1'b1;
          rf_dr_d    = core_wr_idx;
          rf_wdata_d = core_wr_data;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == 3'd7) begin
          state_d = DONE;
        end else begin
          clr_cnt_d  = clr_cnt_q + 3'd1;
          rf_load_d  = 1'b1;
          rf_dr_d    = clr_cnt_q + 3'd1;
          rf_wdata_d = 16'd0;
        end
      end
      DONE: begin
        state_d   = IDLE;
        clr_cnt_d = 3'd0;
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = host_rd_ready;
    rd_data_d  = host_rd_ready ? rf_SR2_OUT : rd_data_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      host_wait_q <= 4'd0;
      clr_cnt_q   <= 3'd0;
      rf_load_q   <= 1'b0;
      rf_dr_q     <= 3'd0;
      rf_wdata_q  <= 16'd0;
      rd_data_q   <= 16'd0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      host_wait_q <= host_wait_d;
      clr_cnt_q   <= clr_cnt_d;
      rf_load_q   <= rf_load_d;
      rf_dr_q     <= rf_dr_d;
      rf_wdata_q  <= rf_wdata_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign core_wr_ready      = core_win;
  assign host_wr_ready      = host_win;
  assign rf_SR2             = core_sr2_use ? core_sr2_idx : host_rd_idx;
  assign rf_load            = rf_load_q;
  assign rf_DR              = rf_dr_q;
  assign rf_Q               = rf_wdata_q;
  assign host_rd_data       = rd_data_q;
  assign host_rd_data_valid = rd_valid_q;
  assign clr_busy           = (state_q != IDLE);
  assign clr_done           = (state_q == DONE);

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: a cycle-level reference model predicts readies and
// queues expected register-file writes and read results; a negedge monitor pops and compares.
module tb_regfile_port_ctrl;

  localparam int STARVE_MAX = 4;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        core_wr_valid, host_wr_valid, host_rd_valid, core_sr2_use, clr_start;
  logic [2:0]  core_wr_idx, host_wr_idx, host_rd_idx, core_sr2_idx;
  logic [15:0] core_wr_data, host_wr_data;
  logic        core_wr_ready, host_wr_ready, host_rd_ready;
  logic [15:0] host_rd_data;
  logic        host_rd_data_valid, clr_busy, clr_done;
  logic [2:0]  rf_DR, rf_SR2;
  logic [15:0] rf_Q, rf_SR2_OUT;
  logic        rf_load;

  regfile_port_ctrl #(.STARVE_MAX(STARVE_MAX)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .core_wr_valid(core_wr_valid), .core_wr_idx(core_wr_idx), .core_wr_data(core_wr_data),
    .core_wr_ready(core_wr_ready),
    .host_wr_valid(host_wr_valid), .host_wr_idx(host_wr_idx), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready),
    .core_sr2_use(core_sr2_use), .core_sr2_idx(core_sr2_idx),
    .host_rd_valid(host_rd_valid), .host_rd_idx(host_rd_idx), .host_rd_ready(host_rd_ready),
    .host_rd_data(host_rd_data), .host_rd_data_valid(host_rd_data_valid),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
    .rf_DR(rf_DR), .rf_Q(rf_Q), .rf_load(rf_load), .rf_SR2(rf_SR2), .rf_SR2_OUT(rf_SR2_OUT)
  );

  always #5 Clk = ~Clk;

  // Register file the controller drives (environment, not the reference model).
  logic [15:0] rf_mem [8];
  always @(posedge Clk) if (Reset_n && rf_load) rf_mem[rf_DR] <= rf_Q;
  assign rf_SR2_OUT = rf_mem[rf_SR2];

  typedef struct packed {
    logic cv; logic [2:0] ci; logic [15:0] cd;
    logic hv; logic [2:0] hi; logic [15:0] hd;
    logic su; logic [2:0] si;
    logic rv; logic [2:0] ri;
    logic cs;
  } stim_t;

  typedef struct packed { logic [2:0] idx; logic [15:0] data; } wr_t;

  int checks = 0;
  int errors = 0;

  wr_t         wq[$];
  logic [15:0] rq[$];

  // Reference model state
  logic [15:0] m_regs [8];
  int          m_wait, m_clr_left;
  logic        m_done_due, m_pend_v, m_rd_pend;
  wr_t         m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t nil();
    stim_t s = '0;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    core_wr_valid = s.cv; core_wr_idx = s.ci; core_wr_data = s.cd;
    host_wr_valid = s.hv; host_wr_idx = s.hi; host_wr_data = s.hd;
    core_sr2_use  = s.su; core_sr2_idx = s.si;
    host_rd_valid = s.rv; host_rd_idx = s.ri;
    clr_start     = s.cs;
  endtask

  task automatic model_reset();
    m_wait = 0; m_clr_left = 0; m_done_due = 0; m_pend_v = 0; m_rd_pend = 0;
    wq.delete(); rq.delete();
  endtask

  task automatic step(input stim_t s);
    logic busy, exp_done, ecr, ehr, err;
    @(posedge Clk); #1;
    drive(s);
    #1;
    busy     = (m_clr_left > 0) || m_done_due;
    exp_done = (m_clr_left == 0) && m_done_due;
    ecr = 1'b0; ehr = 1'b0; err = 1'b0;
    if (!busy && !s.cs) begin
      ehr = s.hv && (!s.cv || m_wait == STARVE_MAX);
      ecr = s.cv && !ehr;
      err = s.rv && !s.su;
    end
    chk("clr_busy", clr_busy, busy);
    chk("clr_done", clr_done, exp_done);
    chk("core_wr_ready", core_wr_ready, ecr);
    chk("host_wr_ready", host_wr_ready, ehr);
    chk("host_rd_ready", host_rd_ready, err);
    chk("rf_SR2", rf_SR2, s.su ? s.si : s.ri);
    chk("rf_load", rf_load, m_pend_v);
    chk("rd_data_valid", host_rd_data_valid, m_rd_pend);

    m_rd_pend = err;
    if (err) rq.push_back(m_regs[s.ri]);
    if (m_pend_v) m_regs[m_pend.idx] = m_pend.data;
    m_pend_v = 1'b0;
    if (m_clr_left > 0) begin
      m_clr_left--;
      if (m_clr_left > 0) begin
        m_pend_v = 1'b1; m_pend.idx = 3'(8 - m_clr_left); m_pend.data = 16'd0;
      end else begin
        m_done_due = 1'b1;
      end
    end else if (m_done_due) begin
      m_done_due = 1'b0;
    end else begin
      if (s.cs) begin
        m_clr_left = 8; m_pend_v = 1'b1; m_pend.idx = 3'd0; m_pend.data = 16'd0;
      end else if (ehr) begin
        m_pend_v = 1'b1; m_pend.idx = s.hi; m_pend.data = s.hd;
      end else if (ecr) begin
        m_pend_v = 1'b1; m_pend.idx = s.ci; m_pend.data = s.cd;
      end
      if (!s.hv || ehr) m_wait = 0;
      else if (m_wait < STARVE_MAX) m_wait++;
    end
    if (m_pend_v) wq.push_back(m_pend);
  endtask

  task automatic settle();
    for (int i = 0; i < 12; i++) step(nil());
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rf_load"}, rf_load, 0);
    chk({tag, "_rf_DR"}, rf_DR, 0);
    chk({tag, "_rf_Q"}, rf_Q, 0);
    chk({tag, "_rd_data"}, host_rd_data, 0);
    chk({tag, "_rd_valid"}, host_rd_data_valid, 0);
    chk({tag, "_clr_busy"}, clr_busy, 0);
    chk({tag, "_clr_done"}, clr_done, 0);
  endtask

  wr_t mon_w;
  logic [15:0] mon_r;
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (rf_load) begin
        if (wq.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          mon_w = wq.pop_front();
          chk("wr_DR", rf_DR, mon_w.idx);
          chk("wr_Q", rf_Q, mon_w.data);
        end
      end
      if (host_rd_data_valid) begin
        if (rq.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          mon_r = rq.pop_front();
          chk("rd_data", host_rd_data, mon_r);
        end
      end
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < 8; i++) begin
      rf_mem[i] = 16'($urandom);
      m_regs[i] = rf_mem[i];
    end
    Reset_n = 1'b0;
    drive(nil());
    model_reset();
    #2;
    chk_reset_outputs("reset");
    @(posedge Clk); #3;
    Reset_n = 1'b1;

    // Core write R3 = 0x1234, registered one cycle later for exactly one cycle
    s = nil(); s.cv = 1; s.ci = 3; s.cd = 16'h1234;
    step(s);
    step(nil());
    chk("lat_rf_load", rf_load, 1);
    chk("lat_rf_DR", rf_DR, 3);
    chk("lat_rf_Q", rf_Q, 16'h1234);
    step(nil());
    chk("lat_rf_load_off", rf_load, 0);

    // Starvation: host forced through on the 5th contended cycle
    for (int k = 0; k < 6; k++) begin
      s = nil(); s.cv = 1; s.ci = 3'($urandom); s.cd = 16'($urandom);
      s.hv = 1; s.hi = 3'($urandom); s.hd = 16'($urandom);
      step(s);
      chk("starve_host", host_wr_ready, (k == 4));
      chk("starve_core", core_wr_ready, (k != 4));
    end
    step(nil());

    // clr_start beats a core write; full walk then done pulse
    s = nil(); s.cv = 1; s.ci = 6; s.cd = 16'h5555; s.cs = 1;
    step(s);
    for (int k = 0; k < 8; k++) begin
      step(nil());
      chk("clr_walk_DR", rf_DR, k);
    end
    settle();

    // Host write R5 = 0xBEEF then read it; then a read blocked by core SR2 use
    s = nil(); s.hv = 1; s.hi = 5; s.hd = 16'hBEEF;
    step(s);
    step(nil()); step(nil());
    s = nil(); s.rv = 1; s.ri = 5;
    step(s);
    s.su = 1; s.si = 2;
    step(s);
    step(nil());

    // Read/write collision on R1: no bypass
    s = nil(); s.hv = 1; s.hi = 1; s.hd = 16'h00AA;
    step(s);
    s = nil(); s.rv = 1; s.ri = 1;
    step(s);
    step(s);
    step(nil());

    // Reset while the clear walk is at counter 3
    for (int i = 0; i < 8; i++) begin
      s = nil(); s.hv = 1; s.hi = 3'(i); s.hd = 16'hA000 + 16'(i);
      step(s);
    end
    step(nil());
    s = nil(); s.cs = 1;
    step(s);
    step(nil()); step(nil()); step(nil());
    @(posedge Clk); #1;
    drive(nil());
    #1;
    chk("midclr_DR_before", rf_DR, 3);
    Reset_n = 1'b0;
    #1;
    chk_reset_outputs("midclr");
    model_reset();
    @(posedge Clk); #3;
    Reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s = nil(); s.rv = 1; s.ri = 3'(i);
      step(s);
    end
    step(nil());

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      s.cv = ($urandom_range(0, 99) < 55);
      s.ci = 3'($urandom); s.cd = 16'($urandom);
      s.hv = ($urandom_range(0, 99) < 50);
      s.hi = 3'($urandom); s.hd = 16'($urandom);
      s.su = ($urandom_range(0, 99) < 40);
      s.si = 3'($urandom);
      s.rv = ($urandom_range(0, 99) < 50);
      s.ri = 3'($urandom);
      s.cs = ($urandom_range(0, 99) < 3);
      step(s);
    end
    settle();
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
